crp_auth_table: RTL
===================

Name: crp_auth_table

Overview:
- Writable, parametrised challenge-response pair (CRP) store for the RO PUF authentication path; supersedes fixed constant lookup tables.
- Holds up to DEPTH entries. Each entry is {valid, challenge, golden response}.
- For each request, scans the table for the challenge and computes the Hamming distance between the freshly measured PUF response and the stored golden response, CHUNK bits per cycle.
- Returns hit, match and distance through a valid/ready response channel.

Parameters:
- ADDR_SZ, 8, challenge width.
- DATA_SZ, 264, response width.
- DEPTH, 16, number of table entries (power of 2 not required, >=1).
- CHUNK, 8, response bits compared per cycle (must divide DATA_SZ).
- HD_THRESH, 26, maximum Hamming distance accepted as a match.
- DEFAULT_RESP, 264'h0, golden response used on a table miss.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous active-high reset.
- wr_en, in, 1: write/insert strobe.
- wr_chal, in, ADDR_SZ: challenge to insert.
- wr_resp, in, DATA_SZ: golden response to insert.
- wr_ready, out, 1: high when a write is accepted this cycle.
- full, out, 1: all entries valid.
- count, out, $clog2(DEPTH+1): number of valid entries.
- req_valid, in, 1: lookup request.
- req_ready, out, 1: request accepted when req_valid && req_ready.
- req_chal, in, ADDR_SZ: challenge to look up.
- req_resp, in, DATA_SZ: measured PUF response.
- rsp_valid, out, 1: result available.
- rsp_ready, in, 1: result consumed when rsp_valid && rsp_ready.
- rsp_hit, out, 1: challenge found in table.
- rsp_match, out, 1: rsp_hd <= HD_THRESH.
- rsp_hd, out, $clog2(DATA_SZ+1): Hamming distance.

Behaviour:
- Reset: all valid bits cleared, count=0, full=0, FSM in IDLE, rsp_valid=0, rsp_hit=0, rsp_match=0, rsp_hd=0. wr_ready and req_ready evaluate to 1 in the first cycle after reset.
- FSM states: IDLE, SEARCH, COMPARE, DONE.
- IDLE, write path: wr_ready=1.
  - If wr_en: when a valid entry with equal challenge exists, overwrite its response; count unchanged.
  - Else if not full: write into the lowest-index invalid slot; count+1.
  - Else (full, new challenge): drop the write; no state change.
- IDLE, request path: req_ready = !wr_en. A write has priority over a request in the same cycle. On handshake, latch req_chal/req_resp, set idx=0, go to SEARCH.
- SEARCH:
  - Examine entry idx each cycle.
  - On valid && equal challenge: hit=1, latch golden response, go to COMPARE.
  - If idx==DEPTH-1 with no hit: hit=0, golden=DEFAULT_RESP, go to COMPARE.
  - Lowest-index hit wins. Cost: idx_hit+1 cycles.
- COMPARE:
  - Each cycle XOR one CHUNK slice (LSB slice first) and add its popcount to the accumulator.
  - Takes DATA_SZ/CHUNK cycles (33 at defaults), then go to DONE.
- DONE:
  - rsp_valid=1; outputs held stable until rsp_ready.
  - On handshake: rsp_valid=0 next cycle, return to IDLE.
- Latency from request handshake to rsp_valid: (idx_hit+1 or DEPTH) + DATA_SZ/CHUNK + 1 cycles.
- wr_ready=0 and req_ready=0 in every state except IDLE; writes outside IDLE are ignored.
- rst asserted mid-operation: returns to IDLE next edge, clears the table, drops any pending response.
- rsp_hd saturates never; its width covers 0..DATA_SZ.

Optional Feature:
- Macro: CRP_ONE_TIME_EN.
- Defined: on the DONE handshake with rsp_hit=1 && rsp_match=1, the hit entry's valid bit clears and count decrements in that cycle. This gives one-time-use CRPs (anti-replay). Misses and mismatches leave the table unchanged.
- Undefined: entries persist until overwritten or reset.

Test Plan:
- Reset, then request chal 8'h13 with resp 0 (DEFAULT_RESP=0) -> rsp_hit=0, rsp_hd=0, rsp_match=1; rsp_valid asserts DEPTH+33+1=50 cycles after the handshake.
- Write chal 8'h2A with golden G; request 8'h2A with G XOR 3 flipped bits -> rsp_hit=1, rsp_hd=3, rsp_match=1. Repeat with 27 flipped bits -> rsp_hd=27, rsp_match=0.
- Fill 16 distinct challenges -> full=1, count=16. Write a 17th challenge -> dropped, count=16. Rewrite an existing challenge with a new response -> a later lookup compares against the new value.
- Assert wr_en and req_valid together in IDLE -> write completes, req_ready=0 that cycle, request accepted the next cycle. Hold rsp_ready=0 for 5 cycles in DONE -> outputs stable; release -> IDLE.
- Assert rst during COMPARE -> rsp_valid stays 0, count=0, subsequent lookups miss.
- With CRP_ONE_TIME_EN defined: a matching lookup on 8'h95 decrements count; a second identical lookup -> rsp_hit=0.

Source files
------------

// File: rtl/crp_auth_table.sv
// Writable challenge-response store with a sequential table scan and a chunked Hamming-distance compare.
// Optional `CRP_ONE_TIME_EN: a matching hit invalidates its entry on the response handshake (anti-replay).
module crp_auth_table #(
  parameter int                 ADDR_SZ      = 8,
  parameter int                 DATA_SZ      = 264,
  parameter int                 DEPTH        = 16,
  parameter int                 CHUNK        = 8,
  parameter int                 HD_THRESH    = 26,
  parameter logic [DATA_SZ-1:0] DEFAULT_RESP = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_SZ-1:0]             wr_chal,
  input  logic [DATA_SZ-1:0]             wr_resp,
  output logic                           wr_ready,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_SZ-1:0]             req_chal,
  input  logic [DATA_SZ-1:0]             req_resp,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_hit,
  output logic                           rsp_match,
  output logic [$clog2(DATA_SZ+1)-1:0]   rsp_hd
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int HW  = $clog2(DATA_SZ+1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NCH = DATA_SZ / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(CHUNK+1);

  typedef enum logic [1:0] {IDLE, SEARCH, COMPARE, DONE} state_t;
  state_t state, state_nxt;

  logic [DEPTH-1:0]              tvld;
  logic [DEPTH-1:0][ADDR_SZ-1:0] tchal;
  logic [DEPTH-1:0][DATA_SZ-1:0] tresp;

  logic [ADDR_SZ-1:0] q_chal;
  logic [DATA_SZ-1:0] q_resp, gold;
  logic [IW-1:0]      idx;
  logic [KW-1:0]      cidx;
  logic [HW-1:0]      acc, acc_nxt;
  logic               hit, match;

  logic               wr_hit, ent_hit;
  logic [IW-1:0]      wr_hit_idx, free_idx;
  logic [CHUNK-1:0]   diff;
  logic [PW-1:0]      pc;

  assign wr_ready  = (state == IDLE);
  assign req_ready = (state == IDLE) && !wr_en;
  assign rsp_valid = (state == DONE);
  assign rsp_hit   = hit;
  assign rsp_match = match;
  assign rsp_hd    = acc;
  assign full      = (count == CW'(DEPTH));
  assign ent_hit   = tvld[idx] && (tchal[idx] == q_chal);

  // Downward scan so the lowest matching / lowest free slot is the one kept.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (tvld[i] && (tchal[i] == wr_chal)) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IW'(i);
      end
      if (!tvld[i]) free_idx = IW'(i);
    end
  end

  // q_resp and gold shift right each COMPARE cycle, so bit slice 0 is always the current chunk.
  always_comb begin
    diff = q_resp[CHUNK-1:0] ^ gold[CHUNK-1:0];
    pc   = '0;
    for (int b = 0; b < CHUNK; b++) pc = pc + PW'(diff[b]);
    acc_nxt = acc + HW'(pc);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && req_ready) state_nxt = SEARCH;
      SEARCH:  if (ent_hit || idx == IW'(DEPTH-1)) state_nxt = COMPARE;
      COMPARE: if (cidx == KW'(NCH-1)) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tvld  <= '0;
      count <= '0;
      idx   <= '0;
      cidx  <= '0;
      acc   <= '0;
      hit   <= 1'b0;
      match <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            if (wr_hit) begin
              tresp[wr_hit_idx] <= wr_resp;
            end else if (!full) begin
              tvld[free_idx]  <= 1'b1;
              tchal[free_idx] <= wr_chal;
              tresp[free_idx] <= wr_resp;
              count           <= count + CW'(1);
            end
          end else if (req_valid) begin
            q_chal <= req_chal;
            q_resp <= req_resp;
            idx    <= '0;
            cidx   <= '0;
            acc    <= '0;
            hit    <= 1'b0;
            match  <= 1'b0;
          end
        end
        // On a hit idx is left pointing at the entry, which DONE may need.
        SEARCH: begin
          if (ent_hit) begin
            hit  <= 1'b1;
            gold <= tresp[idx];
          end else if (idx == IW'(DEPTH-1)) begin
            gold <= DEFAULT_RESP;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        COMPARE: begin
          acc    <= acc_nxt;
          q_resp <= q_resp >> CHUNK;
          gold   <= gold >> CHUNK;
          cidx   <= cidx + KW'(1);
          if (cidx == KW'(NCH-1)) match <= (acc_nxt <= HW'(HD_THRESH));
        end
        DONE: begin
`ifdef CRP_ONE_TIME_EN
          if (rsp_ready && hit && match) begin
            tvld[idx] <= 1'b0;
            count     <= count - CW'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
